// File: rtl/dcache_write_buffer_if.sv
// Bus between the dcache access logic, the posted-write buffer and the memory port.
// Memory handshake: a write transfers on any rising edge with mWEN=1 and mwait=0; maddr/mstore are stable while mWEN is high.
interface dcache_write_buffer_if #(
  parameter int WORD_W = 32
);
  logic              wen;
  logic [WORD_W-1:0] waddr;
  logic [WORD_W-1:0] wdata;
  logic              wfull;
  logic [WORD_W-1:0] lookup_addr;
  logic              hit;
  logic [WORD_W-1:0] ddata;
  logic              wempty;
  logic              mWEN;
  logic [WORD_W-1:0] maddr;
  logic [WORD_W-1:0] mstore;
  logic              mwait;

  // master is the surrounding environment: access logic plus the memory port's mwait
  modport master (
    output wen, waddr, wdata, lookup_addr, mwait,
    input  wfull, hit, ddata, wempty, mWEN, maddr, mstore
  );

  modport slave (
    input  wen, waddr, wdata, lookup_addr, mwait,
    output wfull, hit, ddata, wempty, mWEN, maddr, mstore
  );
endinterface

// File: rtl/dcache_write_buffer.sv
// Posted-write FIFO between dcache access logic and memory: in-order drain,
// merge into the youngest entry, and store-to-load forwarding.
module dcache_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  dcache_write_buffer_if.slave     bus,
  output logic                     dbg_state,
  output logic [$clog2(DEPTH):0]   dbg_count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [PW:0]   CNT_ONE = 1;
  localparam logic [PW:0]   CNT_MAX = (PW+1)'(DEPTH);

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  state_t            state;
  logic [WORD_W-1:0] addr_q [DEPTH];
  logic [WORD_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     head, tail, youngest, idx;
  logic [PW:0]       count;
  logic              full, merge, push, pop;
  logic              hit_c;
  logic [WORD_W-1:0] fwd_c;

  assign youngest = tail - PTR_ONE;
  assign full     = (count == CNT_MAX);

  // The head being presented to memory must stay stable, so it is never merged into.
  assign merge = bus.wen && (count != '0) && (addr_q[youngest] == bus.waddr) &&
                 !((state == S_WRITE) && (youngest == head));
  assign push  = bus.wen && !merge && !full;
  assign pop   = (state == S_WRITE) && !bus.mwait;

  always_ff @(posedge CLK) begin
    if (RST) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      state <= S_IDLE;
    end else begin
      if (push) tail <= tail + PTR_ONE;
      if (pop)  head <= head + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
      if (state == S_IDLE) begin
        if (count != '0) state <= S_WRITE;
      end else begin
        if (pop && !push && (count == CNT_ONE)) state <= S_IDLE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (push) begin
        addr_q[tail] <= bus.waddr;
        data_q[tail] <= bus.wdata;
      end else if (merge) begin
        data_q[youngest] <= bus.wdata;
      end
    end
  end

  // Walk oldest to youngest so the last match found is the youngest one.
  always_comb begin
    hit_c = 1'b0;
    fwd_c = '0;
    idx   = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (((PW+1)'(i) < count) && (addr_q[idx] == bus.lookup_addr)) begin
        hit_c = 1'b1;
        fwd_c = data_q[idx];
      end
    end
  end

  assign bus.hit    = hit_c;
  assign bus.ddata  = fwd_c;
  assign bus.wfull  = full;
  assign bus.wempty = (count == '0);
  assign bus.mWEN   = (state == S_WRITE);
  assign bus.maddr  = (state == S_WRITE) ? addr_q[head] : '0;
  assign bus.mstore = (state == S_WRITE) ? data_q[head] : '0;

  assign dbg_state = (state == S_WRITE);
  assign dbg_count = count;
endmodule
